// File: rtl/sevenseg_scan_mux.sv
// sevenseg_scan_mux
//
// Scan driver for an NDIG-digit common-anode seven-segment display.
// It lights one digit at a time: the shared active-low segment bus shows that
// digit's pattern, and that digit's active-low anode is pulled low. Each digit
// gets a slot of PRESCALE clocks. The first BLANK clocks of every slot are
// dark, so the previous digit's pattern does not ghost onto the next digit.
// All digit patterns are copied into a shadow register once per frame. This
// keeps a frame consistent even if the upstream count changes mid-frame.
//
// Ports
//   clock        rising-edge system clock
//   reset        synchronous, active-high; dominates everything
//   enable       1 = scan and display, 0 = freeze scan state with outputs off
//   digits       7*NDIG active-low patterns; digit k at [7k+6:7k], {g,f,e,d,c,b,a}
//   segments     active-low shared segment bus (registered)
//   anodes       active-low digit enables; at most one low (registered)
//   digit_index  digit currently selected by the scan state
//   frame_start  one-cycle pulse on the cycle the shadow snapshot is taken
module sevenseg_scan_mux #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16,
  localparam int IW      = (NDIG > 1) ? $clog2(NDIG) : 1,
  localparam int CW      = $clog2(PRESCALE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [7*NDIG-1:0] digits,
  output logic [6:0]        segments,
  output logic [NDIG-1:0]   anodes,
  output logic [IW-1:0]     digit_index,
  output logic              frame_start
);

  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic [7*NDIG-1:0]  shadow;

  logic               slot_end;
  logic               frame_wrap;
  logic               lit;
  logic [6:0]         cur_pattern;
  logic [NDIG-1:0]    cur_onehot;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = enable && slot_end && (idx == IDX_LAST);
  assign lit        = enable && (cnt >= CNT_BLANK);

  // Select the current digit with a compare-per-digit mux. Out-of-range idx
  // values cannot occur, but they would select nothing and leave the display
  // dark rather than alias onto another digit.
  always_comb begin
    cur_pattern = 7'h7F;
    cur_onehot  = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx == IW'(k)) begin
        cur_pattern   = shadow[7*k +: 7];
        cur_onehot[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '1;
      segments    <= 7'h7F;
      anodes      <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;

      if (enable) begin
        if (slot_end) begin
          cnt <= '0;
          if (idx == IDX_LAST) begin
            idx <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      if (frame_wrap) begin
        shadow      <= digits;
        frame_start <= 1'b1;
      end

      // The outputs come from the state before this edge. The anode and the
      // segment bus therefore switch together, one clock behind cnt/idx.
      if (lit) begin
        anodes   <= ~cur_onehot;
        segments <= cur_pattern;
      end else begin
        anodes   <= '1;
        segments <= 7'h7F;
      end
    end
  end

  assign digit_index = idx;

endmodule
